// File: rtl/alu_pkg.sv
// ALU shared types: opcode encoding, flag bundle, core FSM states.
// Imported by alu_seq_core and alu_div_seq.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_DIV  = 4'd3,
    OP_SHL  = 4'd4,
    OP_SHR  = 4'd5,
    OP_ROL  = 4'd6,
    OP_ROR  = 4'd7,
    OP_AND  = 4'd8,
    OP_OR   = 4'd9,
    OP_XOR  = 4'd10,
    OP_NOR  = 4'd11,
    OP_NAND = 4'd12,
    OP_XNOR = 4'd13,
    OP_GT   = 4'd14,
    OP_EQ   = 4'd15
  } alu_op_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic overflow;
    logic div_by_zero;
  } alu_flags_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_div_seq.sv
// Restoring unsigned divider, one quotient bit per cycle.
// Ports: clk, rst, start, dividend, divisor -> busy, done (1-cycle pulse), quotient.
module alu_div_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   trial;

  // Remainder stays below the divisor, so a negative trial
  // always shows up in the top bit.
  assign trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem_q <= '0;
        quo_q <= dividend;
        dvs_q <= divisor;
        cnt_q <= CW'(WIDTH);
        busy  <= 1'b1;
      end else if (busy) begin
        if (trial[WIDTH]) begin
          rem_q <= {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
          quo_q <= {quo_q[WIDTH-2:0], 1'b0};
        end else begin
          rem_q <= trial[WIDTH-1:0];
          quo_q <= {quo_q[WIDTH-2:0], 1'b1};
        end
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo_q;

endmodule

// File: rtl/alu_seq_core.sv
// Clocked ALU with valid/ready in and out, registered result + flags.
// Ports: in_valid/in_ready, a, b, alu_sel in; out_valid/out_ready, alu_out, flags, busy out.
module alu_seq_core
  import alu_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit SIGNED_CMP = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             carry_out,
  output logic             zero,
  output logic             overflow,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int SW = $clog2(WIDTH);

  alu_op_e          op;
  alu_state_e       state_q, state_d;
  logic             accept, div_nz, start;
  logic             div_done, div_pulse;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] res;
  alu_flags_t       flg;
  logic [SW-1:0]    sh;
  logic [SW:0]      sh_inv;
  logic [WIDTH:0]   add_w, sub_w;
  logic [2*WIDTH-1:0] mul_w;
  logic             gt;
  logic [WIDTH-1:0] out_q;
  alu_flags_t       flags_q;
  logic             valid_q;

  assign op       = alu_op_e'(alu_sel);
  assign in_ready = !rst && state_q == IDLE && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign div_nz   = op == OP_DIV && b != '0;
  assign start    = accept && div_nz;
  assign div_done = state_q == DIV && div_pulse;

  assign sh     = b[SW-1:0];
  assign sh_inv = (SW+1)'(WIDTH) - {1'b0, sh};
  assign add_w  = {1'b0, a} + {1'b0, b};
  assign sub_w  = {1'b0, a} - {1'b0, b};
  assign mul_w  = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  assign gt     = SIGNED_CMP ? ($signed(a) > $signed(b)) : (a > b);

  always_comb begin
    res = '0;
    flg = '0;
    unique case (op)
      OP_ADD: begin
        res          = add_w[WIDTH-1:0];
        flg.carry    = add_w[WIDTH];
        flg.overflow = (a[WIDTH-1] == b[WIDTH-1]) &&
                       (res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res          = sub_w[WIDTH-1:0];
        flg.carry    = sub_w[WIDTH];
        flg.overflow = (a[WIDTH-1] != b[WIDTH-1]) &&
                       (res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_MUL: begin
        res          = mul_w[WIDTH-1:0];
        flg.overflow = |mul_w[2*WIDTH-1:WIDTH];
      end
      // Only reaches the output register when b is zero.
      OP_DIV: begin
        res             = '1;
        flg.div_by_zero = 1'b1;
      end
      OP_SHL:  res = a << sh;
      OP_SHR:  res = a >> sh;
      OP_ROL:  res = (a << sh) | (a >> sh_inv);
      OP_ROR:  res = (a >> sh) | (a << sh_inv);
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NOR:  res = ~(a | b);
      OP_NAND: res = ~(a & b);
      OP_XNOR: res = ~(a ^ b);
      OP_GT:   res = {{(WIDTH-1){1'b0}}, gt};
      OP_EQ:   res = {{(WIDTH-1){1'b0}}, a == b};
    endcase
    flg.zero = res == '0;
  end

  alu_div_seq #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dividend (a),
    .divisor  (b),
    .busy     (busy),
    .done     (div_pulse),
    .quotient (quo)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = DIV;
      DIV:     if (div_done) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      out_q   <= '0;
      flags_q <= '0;
    end else if (accept && !div_nz) begin
      valid_q <= 1'b1;
      out_q   <= res;
      flags_q <= flg;
    end else if (div_done) begin
      valid_q <= 1'b1;
      out_q   <= quo;
      flags_q <= '{carry: 1'b0, zero: (quo == '0),
                   overflow: 1'b0, div_by_zero: 1'b0};
    end else if (valid_q && out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid   = valid_q;
  assign alu_out     = out_q;
  assign carry_out   = flags_q.carry;
  assign zero        = flags_q.zero;
  assign overflow    = flags_q.overflow;
  assign div_by_zero = flags_q.div_by_zero;

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed self-checking bench for alu_seq_core (WIDTH=8, unsigned GT).
// Covers arithmetic flags, divide latency, backpressure and reset mid-divide.
module tb_alu_seq_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a, b;
  logic [3:0] alu_sel;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] alu_out;
  logic       carry_out, zero, overflow, div_by_zero, busy;

  int checks = 0;
  int errors = 0;

  alu_seq_core #(.WIDTH(8), .SIGNED_CMP(1'b0)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .alu_sel     (alu_sel),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_out     (alu_out),
    .carry_out   (carry_out),
    .zero        (zero),
    .overflow    (overflow),
    .div_by_zero (div_by_zero),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [7:0] va,
                       input logic [7:0] vb);
    in_valid = 1'b1;
    alu_sel  = op;
    a        = va;
    b        = vb;
  endtask

  task automatic chk_res(input string tag, input logic [7:0] r,
                         input logic c, input logic z, input logic o,
                         input logic d);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_out"}, {24'd0, alu_out}, {24'd0, r});
    chk({tag, "_flags"},
        {28'd0, carry_out, zero, overflow, div_by_zero},
        {28'd0, c, z, o, d});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; alu_sel = '0;
    step(); step();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out", {24'd0, alu_out}, 32'd0);
    chk("rst_flags", {27'd0, carry_out, zero, overflow, div_by_zero, busy}, 32'd0);

    rst = 1'b0;
    step();
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // Back-to-back ops with out_ready=1: each result replaces the last.
    drive(4'd0, 8'hFF, 8'h01); step();
    chk_res("add", 8'h00, 1, 1, 0, 0);
    drive(4'd1, 8'h05, 8'h07); step();
    chk_res("sub", 8'hFE, 1, 0, 0, 0);
    drive(4'd2, 8'h10, 8'h10); step();
    chk_res("mul", 8'h00, 0, 1, 1, 0);
    drive(4'd0, 8'h7F, 8'h01); step();
    chk_res("add_ovf", 8'h80, 0, 0, 1, 0);
    drive(4'd14, 8'h80, 8'h7F); step();
    chk_res("gt", 8'h01, 0, 0, 0, 0);
    drive(4'd15, 8'h05, 8'h06); step();
    chk_res("eq", 8'h00, 0, 1, 0, 0);
    drive(4'd5, 8'h80, 8'h03); step();
    chk_res("shr", 8'h10, 0, 0, 0, 0);
    drive(4'd7, 8'h01, 8'h01); step();
    chk_res("ror", 8'h80, 0, 0, 0, 0);
    drive(4'd11, 8'h00, 8'h00); step();
    chk_res("nor", 8'hFF, 0, 0, 0, 0);
    in_valid = 1'b0; step();
    chk("drain_valid", {31'd0, out_valid}, 32'd0);

    // Divide 200/7: 8 busy cycles, result 9 cycles after acceptance.
    drive(4'd3, 8'd200, 8'd7); step();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("div_busy", {30'd0, busy, in_ready}, 32'd2);
      chk("div_nvalid", {31'd0, out_valid}, 32'd0);
      step();
    end
    chk("div_gap", {30'd0, busy, out_valid}, 32'd0);
    step();
    chk_res("div", 8'd28, 0, 0, 0, 0);
    chk("div_done_rdy", {31'd0, in_ready}, 32'd0);
    step();
    chk("div_after", {30'd0, out_valid, in_ready}, 32'd1);

    drive(4'd3, 8'h33, 8'h00); step();
    chk_res("div0", 8'hFF, 0, 0, 0, 1);
    chk("div0_busy", {31'd0, busy}, 32'd0);

    // Backpressure: ROL result held, pending AND waits.
    drive(4'd6, 8'h81, 8'h01); step();
    chk_res("rol", 8'h03, 0, 0, 0, 0);
    out_ready = 1'b0;
    drive(4'd8, 8'h0F, 8'h3C);
    for (int i = 0; i < 5; i++) begin
      step();
      chk_res("hold", 8'h03, 0, 0, 0, 0);
      chk("hold_rdy", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("release_rdy", {31'd0, in_ready}, 32'd1);
    step();
    chk_res("and", 8'h0C, 0, 0, 0, 0);
    in_valid = 1'b0; step();
    chk("and_drain", {31'd0, out_valid}, 32'd0);

    // Reset on the 4th cycle of a divide.
    drive(4'd3, 8'd200, 8'd7); step();
    in_valid = 1'b0;
    step(); step(); step();
    rst = 1'b1; step();
    chk("mid_rst_out",
        {22'd0, alu_out, out_valid, busy},
        32'd0);
    chk("mid_rst_rdy", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_rdy", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("post_rst_quiet", {30'd0, out_valid, busy}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
